// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, data width and frame lengths.
// The TX side reuses the same encodings and constants.
package uart_pkg;

  localparam int DATA_BITS      = 8;
  localparam int FRAME_BITS_8N1 = 10;  // start + 8 data + stop
  localparam int FRAME_BITS_8E1 = 11;  // start + 8 data + even parity + stop

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Even parity bit for a data byte: makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO: 2**RX_SIZE bytes, RX_SIZE+1 bit wrapping pointers.
// A push into a full FIFO is accepted only when a pop frees a slot that cycle.
module uart_rx_fifo import uart_pkg::*; #(
  parameter int RX_SIZE = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [DATA_BITS-1:0] push_data,
  input  logic                 pop,
  output logic [DATA_BITS-1:0] head,
  output logic                 full,
  output logic                 empty
);

  localparam int DEPTH = 2**RX_SIZE;

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [RX_SIZE:0]     wr_ptr, rd_ptr;
  logic                 wr_en, rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[RX_SIZE] != rd_ptr[RX_SIZE]) &&
                 (wr_ptr[RX_SIZE-1:0] == rd_ptr[RX_SIZE-1:0]);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  // Head forced to zero while empty so the output is defined out of reset.
  assign head  = empty ? '0 : mem[rd_ptr[RX_SIZE-1:0]];

  // Pointer update; both may advance in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage array, no reset needed since empty gates the head.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[RX_SIZE-1:0]] <= push_data;
  end

endmodule

// File: rtl/axis_uart_rx_wrapper.sv
// UART receiver with an AXI-Stream output fed from a small FIFO.
// Default build is 8N1. Define UART_RX_PARITY_EN to add an even-parity bit
// between data bit 7 and the stop bit (8E1).
module axis_uart_rx_wrapper import uart_pkg::*; #(
  parameter int RX_SIZE   = 4,
  parameter int clkdiv_rx = 50
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] o_tdata,
  output logic                 o_tvalid,
  input  logic                 o_tready,
  output logic                 o_frame_err,
  output logic                 o_overrun
);

  localparam logic [15:0] BIT_LAST = 16'(clkdiv_rx - 1);
  localparam logic [15:0] HALF_BIT = 16'(clkdiv_rx / 2);
  localparam logic [2:0]  LAST_IDX = 3'(DATA_BITS - 1);

  logic                 rx_s1, rx_s2, rx_prev;
  uart_state_e          state;
  logic [15:0]          baud_cnt;
  logic [2:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 bit_tick, push, pop, full, empty;
`ifdef UART_RX_PARITY_EN
  logic                 par_err;
`endif

  // Two-flop synchronizer plus a delayed copy for falling-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  assign bit_tick = (baud_cnt == BIT_LAST);
  assign o_tvalid = !empty;
  assign pop      = o_tvalid && o_tready;

  // Push happens on the stop-sample cycle itself so o_tvalid follows one cycle later.
  always_comb begin
    push = (state == ST_STOP) && bit_tick && rx_s2;
`ifdef UART_RX_PARITY_EN
    if (par_err) push = 1'b0;
`endif
  end

  // Receive FSM: samples mid-bit, assembles LSB first, reports errors as pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      baud_cnt    <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err     <= 1'b0;
`endif
    end else begin
      o_frame_err <= 1'b0;
      o_overrun   <= push && full && !pop;
      case (state)
        ST_IDLE: begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
          if (rx_prev && !rx_s2) state <= ST_START;
        end
        ST_START: begin
          if (baud_cnt == HALF_BIT) begin
            baud_cnt <= '0;
            // A start bit that is high again at mid-bit was a glitch.
            state    <= rx_s2 ? ST_IDLE : ST_DATA;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        ST_DATA: begin
          if (bit_tick) begin
            baud_cnt <= '0;
            shreg    <= {rx_s2, shreg[DATA_BITS-1:1]};
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
              state <= ST_PARITY;
`else
              state <= ST_STOP;
`endif
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (bit_tick) begin
            baud_cnt <= '0;
            par_err  <= (rx_s2 != even_parity(shreg));
            state    <= ST_STOP;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
`endif
        ST_STOP: begin
          if (bit_tick) begin
            baud_cnt <= '0;
            state    <= ST_IDLE;
            // Bad stop (or bad parity) drops the byte.
            if (!push) o_frame_err <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  uart_rx_fifo #(.RX_SIZE(RX_SIZE)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (shreg),
    .pop       (pop),
    .head      (o_tdata),
    .full      (full),
    .empty     (empty)
  );

endmodule

// File: tb/tb_axis_uart_rx_wrapper.sv
// Self-checking bench for axis_uart_rx_wrapper (RX_SIZE=4, clkdiv_rx=50, 4 MHz clk).
`timescale 1ns/1ps
module tb_axis_uart_rx_wrapper;

  localparam int CD  = 50;
  localparam int RXS = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       o_tready = 1'b1;
  logic [7:0] o_tdata;
  logic       o_tvalid, o_frame_err, o_overrun;

  always #125 clk = ~clk;

  axis_uart_rx_wrapper #(.RX_SIZE(RXS), .clkdiv_rx(CD)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .o_tdata     (o_tdata),
    .o_tvalid    (o_tvalid),
    .o_tready    (o_tready),
    .o_frame_err (o_frame_err),
    .o_overrun   (o_overrun)
  );

  int         checks = 0, errors = 0;
  int         cyc = 0, ferr_cnt = 0, ovr_cnt = 0, rise_cyc = -1;
  logic [7:0] rx_q[$];
  bit         prev_stall = 0, prev_valid = 0, rand_rdy = 0;
  logic [7:0] prev_data = 8'h00;

  // Monitor: collect accepted beats and error pulses, check hold-stability.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_stall = 0;
      prev_valid = 0;
    end else begin
      if (o_tvalid && !prev_valid && rise_cyc < 0) rise_cyc = cyc;
      if (prev_stall) begin
        checks++;
        if (!o_tvalid || o_tdata !== prev_data) begin
          errors++;
          $display("FAIL hold_stable: got valid=%0b data=%02h, need valid=1 data=%02h",
                   o_tvalid, o_tdata, prev_data);
        end
      end
      if (o_tvalid && o_tready) rx_q.push_back(o_tdata);
      if (o_frame_err) ferr_cnt++;
      if (o_overrun)   ovr_cnt++;
      prev_stall = o_tvalid && !o_tready;
      prev_data  = o_tdata;
      prev_valid = o_tvalid;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), need %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
      if (rand_rdy) o_tready = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic clr();
    rx_q.delete();
    ferr_cnt = 0;
    ovr_cnt  = 0;
    rise_cyc = -1;
  endtask

  // One frame, LSB first, followed by one idle bit time.
  task automatic send(input logic [7:0] d, input bit stop_b, input bit par_flip);
    rx = 1'b0;
    tick(CD);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      tick(CD);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^d) ^ par_flip;
    tick(CD);
`else
    if (par_flip) rx = 1'b1;  // no parity slot in 8N1
`endif
    rx = stop_b;
    tick(CD);
    rx = 1'b1;
    tick(CD);
  endtask

  function automatic int head_of(input int idx);
    return (rx_q.size() > idx) ? int'(rx_q[idx]) : -1;
  endfunction

  typedef struct {
    logic [7:0] d;
    bit         stop_b;
    int         exp_beats;
    int         exp_ferr;
  } vec_t;

  vec_t       vt[6];
  logic [7:0] exp_q[$];
  int         exp_ferr, t0;
  logic [7:0] rb;
  bit         good;

  initial begin
    vt[0] = '{8'hA5, 1'b0, 0, 1};
    vt[1] = '{8'h00, 1'b1, 1, 0};
    vt[2] = '{8'hFF, 1'b1, 1, 0};
    vt[3] = '{8'h80, 1'b1, 1, 0};
    vt[4] = '{8'h01, 1'b0, 0, 1};
    vt[5] = '{8'hC3, 1'b1, 1, 0};

    // Reset state
    tick(5);
    chk("rst_tvalid", int'(o_tvalid), 0);
    chk("rst_tdata", int'(o_tdata), 0);
    chk("rst_ferr", int'(o_frame_err), 0);
    chk("rst_ovr", int'(o_overrun), 0);
    rst = 1'b0;
    tick(10);

    // 0x55 single beat, tvalid rising right after the stop sample (~9.5 bits in)
    clr();
    t0 = cyc;
    send(8'h55, 1'b1, 1'b0);
    tick(20);
    chk("b55_beats", rx_q.size(), 1);
    chk("b55_data", head_of(0), 8'h55);
    chk("b55_lat_win", int'(rise_cyc - t0 >= 472 && rise_cyc - t0 <= 486), 1);
    chk("b55_ferr", ferr_cnt, 0);

    // Table of single frames, good and bad stop bits
    foreach (vt[i]) begin
      clr();
      send(vt[i].d, vt[i].stop_b, 1'b0);
      tick(20);
      chk($sformatf("vec%0d_beats", i), rx_q.size(), vt[i].exp_beats);
      if (vt[i].exp_beats > 0) chk($sformatf("vec%0d_data", i), head_of(0), int'(vt[i].d));
      chk($sformatf("vec%0d_ferr", i), ferr_cnt, vt[i].exp_ferr);
      chk($sformatf("vec%0d_tvalid", i), int'(o_tvalid), 0);
    end

    // Start-bit glitch: rejected silently, receiver still works afterwards
    clr();
    rx = 1'b0;
    tick(20);
    rx = 1'b1;
    tick(600);
    chk("glitch_beats", rx_q.size(), 0);
    chk("glitch_ferr", ferr_cnt, 0);
    send(8'h96, 1'b1, 1'b0);
    tick(20);
    chk("post_glitch_data", head_of(0), 8'h96);

    // Fill 16 with consumer stalled, 17th overruns, then drain in order
    clr();
    o_tready = 1'b0;
    for (int i = 0; i <= 16; i++) send(8'(i), 1'b1, 1'b0);
    tick(20);
    chk("ovr_pulses", ovr_cnt, 1);
    chk("ovr_beats_stalled", rx_q.size(), 0);
    chk("ovr_tvalid", int'(o_tvalid), 1);
    chk("ovr_head", int'(o_tdata), 0);
    o_tready = 1'b1;
    tick(30);
    chk("drain_count", rx_q.size(), 16);
    good = 1;
    for (int i = 0; i < 16; i++) if (head_of(i) != i) good = 0;
    chk("drain_order", int'(good), 1);
    chk("drain_empty", int'(o_tvalid), 0);

    // Reset in bit 3 of 0xFF with an earlier byte held: everything discarded
    clr();
    o_tready = 1'b0;
    send(8'h11, 1'b1, 1'b0);
    chk("pre_rst_tvalid", int'(o_tvalid), 1);
    rx = 1'b0;
    tick(CD);
    rx = 1'b1;
    tick(3 * CD + 25);
    rst = 1'b1;
    tick(3);
    chk("mid_rst_tvalid", int'(o_tvalid), 0);
    rst = 1'b0;
    o_tready = 1'b1;
    tick(20);
    clr();
    send(8'h3C, 1'b1, 1'b0);
    tick(20);
    chk("post_rst_beats", rx_q.size(), 1);
    chk("post_rst_data", head_of(0), 8'h3C);
    chk("post_rst_ferr", ferr_cnt, 0);

`ifdef UART_RX_PARITY_EN
    // Even parity: wrong bit drops with frame error, right bit delivers
    clr();
    send(8'h53, 1'b1, 1'b1);
    tick(20);
    chk("par_bad_beats", rx_q.size(), 0);
    chk("par_bad_ferr", ferr_cnt, 1);
    clr();
    send(8'h53, 1'b1, 1'b0);
    tick(20);
    chk("par_ok_data", head_of(0), 8'h53);
    chk("par_ok_ferr", ferr_cnt, 0);
`endif

    // Random bytes, random stop faults, random backpressure vs. ordered model
    clr();
    exp_q.delete();
    exp_ferr = 0;
    rand_rdy = 1;
    for (int i = 0; i < 12; i++) begin
      rb   = 8'($urandom);
      good = ($urandom_range(0, 4) != 0);
      if (good) exp_q.push_back(rb);
      else exp_ferr++;
      send(rb, good, 1'b0);
    end
    rand_rdy = 0;
    o_tready = 1'b1;
    tick(40);
    chk("rand_count", rx_q.size(), exp_q.size());
    chk("rand_ferr", ferr_cnt, exp_ferr);
    chk("rand_ovr", ovr_cnt, 0);
    good = (rx_q.size() == exp_q.size());
    foreach (exp_q[i]) if (head_of(i) != int'(exp_q[i])) good = 0;
    chk("rand_order", int'(good), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_uart_rx_wrapper.md
AXIS_UART_RX_WRAPPER -- requirements
Module: axis_uart_rx_wrapper

Interface
REQ-001 SHALL have parameter RX_SIZE, default 4, meaning log2 of receive FIFO depth (depth = 2**RX_SIZE entries).
REQ-002 SHALL have parameter clkdiv_rx, default 50, meaning clk cycles per UART bit period; legal range 4..65535.
REQ-003 SHALL have port clk  input  1  single system clock; all logic rising-edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port rx  input  1  asynchronous UART serial input, idle high.
REQ-006 SHALL have port o_tdata  output  8  AXI-Stream received byte.
REQ-007 SHALL have port o_tvalid  output  1  AXI-Stream valid; high whenever FIFO non-empty.
REQ-008 SHALL have port o_tready  input  1  AXI-Stream ready from consumer.
REQ-009 SHALL have port o_frame_err  output  1  one-cycle pulse on bad stop bit.
REQ-010 SHALL have port o_overrun  output  1  one-cycle pulse when a good byte is dropped because FIFO full.

Function
REQ-011 SHALL pass rx through a 2-flop synchronizer (reset value 1) before any use.
REQ-012 SHALL implement FSM states IDLE, START, DATA, PARITY (macro only), STOP.
REQ-013 IDLE: on synchronized falling edge -> START, bit counter cleared to 0.
REQ-014 START: at count clkdiv_rx/2 (integer division) sample; low -> DATA, high -> IDLE (glitch rejected, nothing reported).
REQ-015 DATA: sample every clkdiv_rx cycles thereafter, 8 bits LSB first; after bit 7 -> PARITY if compiled in, else STOP.
REQ-016 STOP: sample one bit period later; high -> push byte; low -> drop byte, pulse o_frame_err; either way -> IDLE same cycle.
REQ-017 Push SHALL occur on the stop-sample cycle; o_tvalid SHALL rise on the next cycle when FIFO was empty (latency 1 cycle).
REQ-018 Pop SHALL occur on any cycle with o_tvalid && o_tready; o_tdata SHALL show FIFO head, stable while o_tvalid && !o_tready.
REQ-019 Push to full FIFO SHALL be accepted only if a pop occurs same cycle; otherwise byte dropped and o_overrun pulsed.
REQ-020 Simultaneous push/pop on empty FIFO: byte stored; o_tvalid rises next cycle (no bypass).
REQ-021 FIFO pointers SHALL be RX_SIZE+1 bits wide and wrap modulo 2**(RX_SIZE+1); full when MSBs differ and rest equal.
REQ-022 Baud counter SHALL be 16 bits; reload to 0 on each sample.

Reset
REQ-023 On rst: FSM IDLE, counters 0, FIFO empty, o_tvalid 0, o_tdata 0, o_frame_err 0, o_overrun 0, synchronizer 1.
REQ-024 rst asserted mid-frame SHALL discard the partial byte and FIFO contents; after release, receiver waits for a fresh falling edge.

Configuration
REQ-025 Macro UART_RX_PARITY_EN SHALL compile in even-parity checking.
REQ-026 With macro: PARITY state samples one bit after bit 7; mismatch drops byte and pulses o_frame_err; frame 11 bits.
REQ-027 Without macro: no PARITY state, no parity logic; frame 10 bits (8N1).

Structure
REQ-028 Shared package uart_pkg SHALL hold FSM state encodings, DATA_BITS=8 and frame-length constants, reused by the TX side.
REQ-029 FIFO SHALL be a sub-module named uart_rx_fifo (parameter RX_SIZE, push/pop/full/empty).

Verification
REQ-030 clk 4 MHz, clkdiv_rx=50, o_tready=1, send 0x55 8N1 -> single o_tvalid beat with o_tdata=0x55 one cycle after stop sample.
REQ-031 rx low pulse of 20 cycles then high -> no o_tvalid, no o_frame_err, FSM back in IDLE.
REQ-032 Send 0xA5 with stop bit held low -> o_frame_err one-cycle pulse, FIFO stays empty.
REQ-033 o_tready=0, send 17 bytes 0x00..0x10 (RX_SIZE=4) -> bytes 0x00..0x0F held, o_overrun pulse on 17th; then o_tready=1 drains 0x00..0x0F in order.
REQ-034 Assert rst during bit 3 of 0xFF, release, send 0x3C -> only 0x3C delivered.
REQ-035 With UART_RX_PARITY_EN, send 0x53 with odd parity bit -> o_frame_err pulse, no data; correct parity -> 0x53 delivered.
